// File: rtl/fpu_int_to_fp80_multi.sv
// fpu_int_to_fp80_multi: iterative signed 16/32/64-bit integer to 80-bit extended converter
// with a coarse/fine normalise loop and an enable/busy/done handshake.
module fpu_int_to_fp80_multi #(
  parameter int MAX_INT_WIDTH = 64,
  parameter int SHIFT_STEP    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [1:0]               size,
  input  logic [MAX_INT_WIDTH-1:0] int_in,
  output logic [79:0]              fp_out,
  output logic                     busy,
  output logic                     done
);
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t      state_q;
  logic [63:0] wide, op, mag_d, mant_q;
  logic [14:0] exp_q;
  logic        sign_q, busy_q, done_q;
  logic [79:0] fp_q;
  // Sign-extending to 64 bits first makes narrower slices clamp to MAX_INT_WIDTH for free.
  assign wide   = 64'($signed(int_in));
  assign op     = size == 2'b00 ? 64'($signed(wide[15:0])) :
                  size == 2'b01 ? 64'($signed(wide[31:0])) : wide;
  assign mag_d  = op[63] ? 64'(-op) : op;
  assign fp_out = fp_q;
  assign busy   = busy_q;
  assign done   = done_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fp_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mant_q  <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (enable) begin
            busy_q <= 1'b1;
            sign_q <= op[63];
            mant_q <= mag_d;
            exp_q  <= 15'h403E;
            if (mag_d == 64'd0) begin
              fp_q    <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= NORM;
            end
          end
        end
        NORM: begin
          if (mant_q[63]) begin
            fp_q    <= {sign_q, exp_q, mant_q};
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (~|mant_q[63 -: SHIFT_STEP]) begin
            mant_q <= mant_q << SHIFT_STEP;
            exp_q  <= exp_q - 15'(SHIFT_STEP);
          end else begin
            mant_q <= mant_q << 1;
            exp_q  <= exp_q - 15'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_int_to_fp80_multi.sv
// tb_fpu_int_to_fp80_multi: directed vectors for fpu_int_to_fp80_multi (MAX_INT_WIDTH=64, SHIFT_STEP=8).
module tb_fpu_int_to_fp80_multi;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [63:0] int_in = '0;
  logic [79:0] fp_out;
  logic        busy, done;
  int          nvec = 0, nmis = 0;

  fpu_int_to_fp80_multi #(.MAX_INT_WIDTH(64), .SHIFT_STEP(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .size(size),
    .int_in(int_in), .fp_out(fp_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Edges are counted after the accept edge; lat=0 means done is already high after it.
  task automatic conv(input string tag, input logic [1:0] sz, input logic [63:0] v,
                      input logic [79:0] efp, input int elat);
    int lat;
    int bl;
    lat = 0;
    bl = 0;
    @(negedge clk);
    size = sz;
    int_in = v;
    enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    while (!done && lat < 40) begin
      if (!busy) bl++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_fp"}, fp_out, efp);
    chk({tag, "_lat"}, 80'(lat), 80'(elat));
    chk({tag, "_busy_lo"}, 80'(bl), 80'd0);
    chk({tag, "_busy_done"}, 80'(busy), 80'd1);
    @(posedge clk);
    #1;
    chk({tag, "_done_end"}, 80'(done), 80'd0);
    chk({tag, "_busy_end"}, 80'(busy), 80'd0);
  endtask

  initial begin
    int lat;
    int dn;
    #12;
    chk("rst_fp", fp_out, 80'h0);
    chk("rst_busy", 80'(busy), 80'd0);
    chk("rst_done", 80'(done), 80'd0);
    @(negedge clk);
    reset = 1'b1;

    conv("two",     2'b01, 64'd2,                   80'h4000_8000000000000000, 14);
    conv("m1_16",   2'b00, 64'h0000_0000_0000_FFFF, 80'hBFFF_8000000000000000, 15);
    conv("min64",   2'b10, 64'h8000_0000_0000_0000, 80'hC03E_8000000000000000, 1);
    conv("hi_ign",  2'b00, 64'h0000_0000_0001_8000, 80'hC00E_8000000000000000, 7);
    conv("zero",    2'b01, 64'd0,                   80'h0,                     0);
    conv("three32", 2'b01, 64'hFFFF_FFFF_0000_0003, 80'h4000_C000000000000000, 14);
    conv("rsvd",    2'b11, 64'd1,                   80'h3FFF_8000000000000000, 15);
    conv("max64",   2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 80'h403D_FFFFFFFFFFFFFFFE, 2);
    conv("m1_32",   2'b01, 64'h0000_0000_FFFF_FFFF, 80'hBFFF_8000000000000000, 15);

    // Enable while busy must neither restart nor queue.
    @(negedge clk);
    size = 2'b01; int_in = 64'd1; enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    int_in = 64'd5; enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    lat = 3;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("ign_fp", fp_out, 80'h3FFF_8000000000000000);
    chk("ign_lat", 80'(lat), 80'd15);
    repeat (2) @(posedge clk);
    #1 chk("ign_noqueue", 80'(busy), 80'd0);

    // Enable held through DONE is re-accepted right after returning to IDLE.
    @(negedge clk);
    size = 2'b00; int_in = 64'hFFFF; enable = 1'b1;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("hold_done", 80'(done), 80'd1);
    @(posedge clk);
    #1 chk("hold_idle", 80'(busy), 80'd0);
    @(posedge clk);
    #1 chk("hold_reacc", 80'(busy), 80'd1);
    enable = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("hold_fp", fp_out, 80'hBFFF_8000000000000000);
    chk("hold_lat", 80'(lat), 80'd15);
    @(posedge clk);

    // Asynchronous reset mid-conversion aborts with no done.
    @(negedge clk);
    size = 2'b01; int_in = 64'd1; enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("abort_pre_busy", 80'(busy), 80'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 80'(busy), 80'd0);
    chk("abort_done", 80'(done), 80'd0);
    chk("abort_fp", fp_out, 80'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    dn = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (done) dn++;
    end
    chk("abort_nodone", 80'(dn), 80'd0);
    conv("five", 2'b01, 64'd5, 80'h4001_A000000000000000, 13);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
